// File: rtl/fetch_buffer_pkg.sv
// Shared defaults and helpers for the fetch-to-decode buffer.
package fetch_buffer_pkg;

  localparam int unsigned FB_DEPTH_DEFAULT = 4;
  localparam int unsigned FB_ID_W_DEFAULT  = 3;
  localparam int unsigned FB_ERR_W_DEFAULT = 5;

  // Counters need one extra bit so that a completely full buffer is representable.
  function automatic int unsigned fb_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_credits.sv
// Occupancy/reservation bookkeeping for fetch_buffer: credits and sticky overflow.
module fetch_buffer_credits
  import fetch_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = FB_DEPTH_DEFAULT,
  localparam int unsigned CW    = fb_cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          consume_i,
  input  logic          request_i,
  output logic          accept_o,
  output logic [CW-1:0] occupied_o,
  output logic          credit_available_o,
  output logic          overflow_error_o
);

  logic [CW-1:0] occupied_q, occupied_d;
  logic [CW-1:0] reserved_q, reserved_d;
  logic          overflow_q, overflow_d;
  logic          overflow_s;
  logic          accept_s;
  logic [CW:0]   committed_s;

  // Next-state for counters; an overflowing push leaves everything but the sticky flag untouched.
  always_comb begin
    overflow_s = push_i & ~flush_i & ~pop_i & (occupied_q == CW'(DEPTH));
    accept_s   = push_i & ~flush_i & ~overflow_s;
    occupied_d = occupied_q;
    reserved_d = reserved_q;
    overflow_d = overflow_q | overflow_s;
    if (flush_i) begin
      occupied_d = '0;
      reserved_d = '0;
    end else if (overflow_s) begin
      occupied_d = occupied_q;
      reserved_d = reserved_q;
    end else begin
      case ({accept_s, pop_i})
        2'b10:   occupied_d = occupied_q + CW'(1);
        2'b01:   occupied_d = occupied_q - CW'(1);
        default: occupied_d = occupied_q;
      endcase
      if (request_i & ~consume_i) begin
        reserved_d = reserved_q + CW'(1);
      end else if (~request_i & consume_i & (reserved_q != '0)) begin
        reserved_d = reserved_q - CW'(1);
      end else begin
        reserved_d = reserved_q;
      end
    end
  end

  // Counter and overflow state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied_q <= '0;
      reserved_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      occupied_q <= occupied_d;
      reserved_q <= reserved_d;
      overflow_q <= overflow_d;
    end
  end

  assign committed_s        = {1'b0, occupied_q} + {1'b0, reserved_q};
  assign credit_available_o = committed_s < (CW+1)'(DEPTH);
  assign accept_o           = accept_s;
  assign occupied_o         = occupied_q;
  assign overflow_error_o   = overflow_q;

endmodule

// File: rtl/fetch_buffer.sv
// In-order fetch-to-decode queue with credit-based slot reservation.
// Optional same-cycle empty-buffer bypass enabled by FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH_DEFAULT,
  parameter int unsigned ID_W  = FB_ID_W_DEFAULT,
  parameter int unsigned ERR_W = FB_ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fetch_request,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [31:0]      fetch_instruction,
  input  logic [ID_W-1:0]  fetch_id,
  input  logic             fetch_ok,
  input  logic [ERR_W-1:0] fetch_error_code,
  output logic             credit_available,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_instruction,
  output logic [ID_W-1:0]  dec_id,
  output logic             dec_ok,
  output logic [ERR_W-1:0] dec_error_code,
  output logic             overflow_error
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = fb_cnt_width(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instruction;
    logic [ID_W-1:0]  id;
    logic             ok;
    logic [ERR_W-1:0] error_code;
  } entry_t;

  entry_t        entries_q [DEPTH];
  entry_t        incoming_s;
  entry_t        head_s;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occupied_s;
  logic          stored_valid_s;
  logic          push_s;
  logic          store_push_s;
  logic          pop_s;
  logic          accept_s;

  assign incoming_s     = '{pc: fetch_pc, instruction: fetch_instruction, id: fetch_id,
                            ok: fetch_ok, error_code: fetch_error_code};
  assign stored_valid_s = (occupied_s != '0);
  assign push_s         = fetch_valid & ~flush;
  assign pop_s          = stored_valid_s & dec_ready & ~flush;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic bypass_s;
  assign bypass_s     = push_s & ~stored_valid_s;
  // A bypassed entry taken by decode never touches storage, but still returns its reservation.
  assign store_push_s = push_s & ~(bypass_s & dec_ready);
`else
  assign store_push_s = push_s;
`endif

  fetch_buffer_credits #(
    .DEPTH (DEPTH)
  ) u_credits (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush),
    .push_i             (store_push_s),
    .pop_i              (pop_s),
    .consume_i          (push_s),
    .request_i          (fetch_request),
    .accept_o           (accept_s),
    .occupied_o         (occupied_s),
    .credit_available_o (credit_available),
    .overflow_error_o   (overflow_error)
  );

  // Pointer next-state; flush rewinds both to slot 0.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      wr_ptr_d = wr_ptr_q + PW'(accept_s);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      entries_q[wr_ptr_q] <= incoming_s;
    end
  end

  // Decode-side view of the head entry.
  always_comb begin
    head_s    = entries_q[rd_ptr_q];
    dec_valid = stored_valid_s;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (bypass_s) begin
      head_s    = incoming_s;
      dec_valid = 1'b1;
    end else begin
      head_s    = entries_q[rd_ptr_q];
      dec_valid = stored_valid_s;
    end
`endif
    dec_pc          = head_s.pc;
    dec_instruction = head_s.instruction;
    dec_id          = head_s.id;
    dec_ok          = head_s.ok;
    dec_error_code  = head_s.error_code;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model plus directed and random traffic.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int ERR_W = 5;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             fetch_request;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_instruction;
  logic [ID_W-1:0]  fetch_id;
  logic             fetch_ok;
  logic [ERR_W-1:0] fetch_error_code;
  logic             credit_available;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_instruction;
  logic [ID_W-1:0]  dec_id;
  logic             dec_ok;
  logic [ERR_W-1:0] dec_error_code;
  logic             overflow_error;

  fetch_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_request(fetch_request),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
    .fetch_id(fetch_id), .fetch_ok(fetch_ok), .fetch_error_code(fetch_error_code),
    .credit_available(credit_available), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instruction(dec_instruction), .dec_id(dec_id), .dec_ok(dec_ok),
    .dec_error_code(dec_error_code), .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      ins;
    logic [ID_W-1:0]  id;
    logic             ok;
    logic [ERR_W-1:0] err;
  } ent_t;

  ent_t mq[$];
  int   mres;
  bit   movf;
  bit   chk_en;
  int   n_vec;
  int   n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_ent();
    ent_t e;
    e.pc  = fetch_pc;
    e.ins = fetch_instruction;
    e.id  = fetch_id;
    e.ok  = fetch_ok;
    e.err = fetch_error_code;
    return e;
  endfunction

  task automatic res_update(input bit req, input bit consumed);
    if (req && !consumed) mres++;
    else if (!req && consumed && mres > 0) mres--;
  endtask

  // Reference model: one clock of the buffer's rules applied to the queue.
  task automatic model_step();
    int occ;
    bit pop;
    if (flush) begin
      mq.delete();
      mres = 0;
    end else begin
      occ = mq.size();
      pop = (occ != 0) && dec_ready;
      if (BYP && occ == 0 && fetch_valid && dec_ready) begin
        res_update(fetch_request, 1'b1);
      end else if (fetch_valid && occ == DEPTH && !pop) begin
        movf = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (fetch_valid) mq.push_back(cur_ent());
        res_update(fetch_request, fetch_valid);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mres = 0;
      movf = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic compare_now();
    int   occ;
    bit   byp;
    bit   ev;
    ent_t e;
    occ = mq.size();
    byp = BYP && occ == 0 && fetch_valid && !flush;
    ev  = (occ != 0) || byp;
    chk("dec_valid", 32'(dec_valid), 32'(ev));
    if (ev) begin
      e = byp ? cur_ent() : mq[0];
      chk("dec_pc", dec_pc, e.pc);
      chk("dec_instruction", dec_instruction, e.ins);
      chk("dec_id", 32'(dec_id), 32'(e.id));
      chk("dec_ok", 32'(dec_ok), 32'(e.ok));
      chk("dec_error_code", 32'(dec_error_code), 32'(e.err));
    end
    chk("credit_available", 32'(credit_available), 32'((occ + mres) < DEPTH));
    chk("overflow_error", 32'(overflow_error), 32'(movf));
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) compare_now();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic ok, input logic [ERR_W-1:0] err);
    fetch_valid       = 1'b1;
    fetch_pc          = pc;
    fetch_instruction = pc ^ 32'hA5A5_0000;
    fetch_id          = pc[ID_W+1:2];
    fetch_ok          = ok;
    fetch_error_code  = err;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_request = 1'b0; fetch_valid = 1'b0;
    fetch_pc = 32'h0; fetch_instruction = 32'h0; fetch_id = '0; fetch_ok = 1'b1;
    fetch_error_code = '0; dec_ready = 1'b0;
    chk_en = 1'b0; n_vec = 0; n_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dec_valid", 32'(dec_valid), 32'd0);
    chk("reset_credit", 32'(credit_available), 32'd1);
    chk("reset_overflow", 32'(overflow_error), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Four reservations exhaust the credits, then four completions fill the buffer.
    for (int i = 0; i < 4; i++) begin
      fetch_request = 1'b1;
      tick();
    end
    fetch_request = 1'b0;
    chk("t1_credit_after_4_req", 32'(credit_available), 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(4 * i), 1'b1, '0);
      tick();
      if (i == 0) begin
        chk("t1_dec_valid_first", 32'(dec_valid), 32'd1);
        chk("t1_dec_pc_first", dec_pc, 32'h100);
      end
    end
    fetch_valid = 1'b0;

    // Full buffer streaming: simultaneous push and pop keep it full.
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_push(32'h110 + 32'(4 * i), 1'b1, '0);
      tick();
      if (i == 0) chk("t2_dec_pc_second", dec_pc, 32'h104);
      chk("t2_credit_full", 32'(credit_available), 32'd0);
    end
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    chk("t2_no_overflow", 32'(overflow_error), 32'd0);

    // Push into a full buffer without a pop.
    set_push(32'h999, 1'b1, '0);
    tick();
    fetch_valid = 1'b0;
    chk("t4_overflow_set", 32'(overflow_error), 32'd1);
    chk("t4_head_unchanged", dec_pc, 32'h118);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_overflow_held", 32'(overflow_error), 32'd1);

    // Flush with two queued, one reserved and a completion in the same cycle.
    for (int i = 0; i < 3; i++) begin
      fetch_request = 1'b1;
      tick();
    end
    fetch_request = 1'b0;
    set_push(32'h300, 1'b1, '0); tick();
    set_push(32'h304, 1'b1, '0); tick();
    set_push(32'h308, 1'b1, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0; fetch_valid = 1'b0;
    chk("t3_dec_valid_after_flush", 32'(dec_valid), 32'd0);
    chk("t3_credit_after_flush", 32'(credit_available), 32'd1);
    set_push(32'h30C, 1'b1, '0); tick();
    fetch_valid = 1'b0;
    chk("t3_post_flush_pc", dec_pc, 32'h30C);
    chk("t3_overflow_still", 32'(overflow_error), 32'd1);

    // Faulting fetch travels in order with normal entries.
    set_push(32'h400, 1'b1, '0); tick();
    set_push(32'h404, 1'b0, 5'd1); tick();
    fetch_valid = 1'b0;
    dec_ready = 1'b1;
    tick();
    chk("t5_head_400", dec_pc, 32'h400);
    tick();
    chk("t5_fault_pc", dec_pc, 32'h404);
    chk("t5_fault_ok", 32'(dec_ok), 32'd0);
    chk("t5_fault_err", 32'(dec_error_code), 32'd1);
    tick();
    dec_ready = 1'b0;
    chk("t5_drained", 32'(dec_valid), 32'd0);

`ifdef FETCH_BUFFER_BYPASS_EN
    set_push(32'h200, 1'b1, '0);
    dec_ready = 1'b1;
    #1;
    chk("byp_dec_valid", 32'(dec_valid), 32'd1);
    chk("byp_dec_pc", dec_pc, 32'h200);
    tick();
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    #1;
    chk("byp_not_stored", 32'(dec_valid), 32'd0);
`endif

    // Asynchronous reset in the middle of a cycle.
    set_push(32'h500, 1'b1, '0); tick();
    fetch_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
    chk("midrst_credit", 32'(credit_available), 32'd1);
    chk("midrst_overflow", 32'(overflow_error), 32'd0);
    tick();
    rst = 1'b0;

    // Randomized traffic; requests only while the model grants a credit.
    for (int i = 0; i < 2000; i++) begin
      flush         = ($urandom_range(0, 39) == 0);
      fetch_request = ((mq.size() + mres) < DEPTH) && ($urandom_range(0, 1) == 1);
      fetch_valid   = ($urandom_range(0, 2) != 0);
      fetch_pc          = $urandom;
      fetch_instruction = $urandom;
      fetch_id          = ID_W'($urandom);
      fetch_ok          = ($urandom_range(0, 3) != 0);
      fetch_error_code  = ERR_W'($urandom);
      dec_ready     = ($urandom_range(0, 2) != 0);
      tick();
    end
    flush = 1'b0; fetch_request = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
